// File: rtl/mor1kx_rf_shadow_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mor1kx_rf_shadow_seq_pkg
//  Description : Shared types and helpers for the shadow GPR copy sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package mor1kx_rf_shadow_seq_pkg;

    // Copy direction: save moves set 0 into a shadow set, restore moves it back.
    typedef enum logic {
        DIR_SAVE    = 1'b0,
        DIR_RESTORE = 1'b1
    } seq_dir_e;

    // Full RF address width: per-set index plus enough bits to select set 0
    // and every shadow set.  Kept identical to the register file's own sizing.
    function automatic int rf_addr_width(input int addr_w, input int num_shadow);
        return addr_w + $clog2(num_shadow + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mor1kx_rf_shadow_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mor1kx_rf_shadow_seq
//  Description : Copies the whole GPR set 0 to / from one shadow GPR set for
//                fast context entry and exit.  Owns a private RF read port and
//                borrows the shared write port whenever writeback is idle.
//  Revision    : 1.0  initial release
// ============================================================================
module mor1kx_rf_shadow_seq
    import mor1kx_rf_shadow_seq_pkg::*;
#(
    parameter int OPTION_RF_ADDR_WIDTH     = 5,
    parameter int OPTION_RF_WORDS          = 32,
    parameter int OPTION_RF_NUM_SHADOW_GPR = 1,
    parameter int OPTION_OPERAND_WIDTH     = 32,
    localparam int RF_ADDR_WIDTH = rf_addr_width(OPTION_RF_ADDR_WIDTH, OPTION_RF_NUM_SHADOW_GPR),
    localparam int SEL_WIDTH     = RF_ADDR_WIDTH - OPTION_RF_ADDR_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            save_req_i,
    input  logic                            restore_req_i,
    input  logic [SEL_WIDTH-1:0]            shadow_sel_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o,
    input  logic                            wb_rf_wb_i,
    input  logic [RF_ADDR_WIDTH-1:0]        wb_rfd_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] result_i,
    output logic                            seq_re_o,
    output logic [RF_ADDR_WIDTH-1:0]        seq_rdad_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] seq_rddat_i,
    output logic                            seq_we_o,
    output logic [RF_ADDR_WIDTH-1:0]        seq_wradr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] seq_wrdat_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [SEL_WIDTH-1:0]            SEL_ZERO = '0;
    localparam logic [OPTION_RF_ADDR_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [OPTION_RF_ADDR_WIDTH-1:0] CNT_LAST = OPTION_RF_ADDR_WIDTH'(OPTION_RF_WORDS - 1);

    logic [1:0]                      state_q;
    seq_dir_e                        dir_q;
    logic [SEL_WIDTH-1:0]            sel_q;
    logic [OPTION_RF_ADDR_WIDTH-1:0] cnt_q;
    logic [OPTION_OPERAND_WIDTH-1:0] hold_q;
    logic                            fwd_q;
    logic                            first_q;
    logic                            busy_q;
    logic                            done_q;
    logic                            err_q;
    logic                            re_q;
    logic [RF_ADDR_WIDTH-1:0]        rdad_q;

    logic                            w_req;
    logic                            w_sel_ok;
    logic [OPTION_RF_ADDR_WIDTH-1:0] w_cnt_inc;
    logic [RF_ADDR_WIDTH-1:0]        w_src_adr;
    logic [RF_ADDR_WIDTH-1:0]        w_dst_adr;
    logic [RF_ADDR_WIDTH-1:0]        w_nxt_src;
    logic                            w_fwd_hit;
    logic [OPTION_OPERAND_WIDTH-1:0] w_rd_word;
    logic                            w_wr_go;

    assign w_req     = save_req_i | restore_req_i;
    assign w_sel_ok  = (shadow_sel_i != SEL_ZERO) &&
                       (int'(shadow_sel_i) <= OPTION_RF_NUM_SHADOW_GPR);
    assign w_cnt_inc = cnt_q + 1'b1;

    // Source / destination addresses of the current word and the next read.
    always_comb begin
        if (dir_q == DIR_SAVE) begin
            w_src_adr = {SEL_ZERO, cnt_q};
            w_dst_adr = {sel_q, cnt_q};
            w_nxt_src = {SEL_ZERO, w_cnt_inc};
        end else begin
            w_src_adr = {sel_q, cnt_q};
            w_dst_adr = {SEL_ZERO, cnt_q};
            w_nxt_src = {sel_q, w_cnt_inc};
        end
    end

    // A writeback to the word being copied supersedes whatever the RAM returns,
    // since the RAM has no read-during-write bypass.
    assign w_fwd_hit = wb_rf_wb_i && (wb_rfd_adr_i == w_src_adr);

    // Fresh RAM data is only valid on the first WR cycle, and only if no
    // writeback was forwarded during the RD cycle; otherwise hold_q is newest.
    assign w_rd_word = (first_q && !fwd_q) ? seq_rddat_i : hold_q;

    // Writeback owns the shared port; the sequencer writes only when it is idle.
    assign w_wr_go   = (state_q == ST_WR) && !wb_rf_wb_i;

    assign seq_we_o    = w_wr_go;
    assign seq_wradr_o = (state_q == ST_WR) ? w_dst_adr : '0;
    assign seq_wrdat_o = (state_q == ST_WR) ? w_rd_word : '0;
    assign seq_re_o    = re_q;
    assign seq_rdad_o  = rdad_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

    // Copy sequencer: IDLE -> (RD -> WR) x OPTION_RF_WORDS -> DONE -> IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_SAVE;
            sel_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            fwd_q   <= 1'b0;
            first_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            re_q    <= 1'b0;
            rdad_q  <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            re_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_req) begin
                        if (!w_sel_ok) begin
                            err_q <= 1'b1;
                        end else begin
                            // Save has priority when both requests coincide.
                            dir_q   <= save_req_i ? DIR_SAVE : DIR_RESTORE;
                            sel_q   <= shadow_sel_i;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            re_q    <= 1'b1;
                            rdad_q  <= save_req_i ? {SEL_ZERO, CNT_ZERO}
                                                  : {shadow_sel_i, CNT_ZERO};
                            state_q <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    first_q <= 1'b1;
                    fwd_q   <= w_fwd_hit;
                    if (w_fwd_hit) begin
                        hold_q <= result_i;
                    end
                    state_q <= ST_WR;
                end
                ST_WR: begin
                    first_q <= 1'b0;
                    hold_q  <= w_fwd_hit ? result_i : w_rd_word;
                    if (w_wr_go) begin
                        if (cnt_q == CNT_LAST) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            cnt_q   <= w_cnt_inc;
                            re_q    <= 1'b1;
                            rdad_q  <= w_nxt_src;
                            state_q <= ST_RD;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
